// File: rtl/logic_op_scheduler_pkg.sv
// Shared definitions for the logic-op scheduler: op codes, FSM states and
// the reserved-op helper.
package logic_op_pkg;

    localparam int OPW = 3;

    typedef enum logic [OPW-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOT  = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    function automatic logic is_reserved(input logic [OPW-1:0] op);
        return (op == OP_RSVD);
    endfunction

endpackage

// File: rtl/logic_op_scheduler_unit.sv
// Combinational W-bit two-operand bitwise logic unit; the reserved op
// yields zero and raises the error flag.
module logic_op_unit
    import logic_op_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    input  logic [OPW-1:0] i_op,
    output logic [W-1:0]   o_y,
    output logic           o_err
);

    always_comb begin
        o_y   = '0;
        o_err = is_reserved(i_op);
        case (op_e'(i_op))
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_NAND: o_y = ~(i_a & i_b);
            OP_NOT:  o_y = ~i_b;
            OP_NOR:  o_y = ~(i_a | i_b);
            OP_XOR:  o_y = i_a ^ i_b;
            OP_XNOR: o_y = ~(i_a ^ i_b);
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/logic_op_scheduler.sv
// Round-robin scheduler sharing one logic unit among NREQ requesters, with a
// single registered result stage under valid/ready backpressure.
module logic_op_scheduler
    import logic_op_pkg::*;
#(
    parameter int W    = 8,
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3*NREQ-1:0] req_op,
    input  logic [W*NREQ-1:0] req_a,
    input  logic [W*NREQ-1:0] req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_data,
    output logic [IDW-1:0]    res_id,
    output logic              res_err,
    input  logic              clr_count,
    output logic [CNTW-1:0]   op_count
);

    state_e          r_state, w_state_nxt;
    logic [IDW-1:0]  r_ptr;
    logic [W-1:0]    r_data_p1;
    logic [IDW-1:0]  r_id_p1;
    logic            r_err_p1;
    logic [CNTW-1:0] r_count;

    logic            w_load, w_any, w_xfer, w_err;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gnt_idx;
    logic [OPW-1:0]  w_op;
    logic [W-1:0]    w_a, w_b, w_y;

    assign res_valid = (r_state == ST_FULL);
    assign w_load    = !res_valid || res_ready;

    // Search starts just after the last served requester so it drops to last priority.
    always_comb begin
        int idx;
        idx       = 0;
        w_grant   = '0;
        w_gnt_idx = '0;
        w_any     = 1'b0;
        w_op      = '0;
        w_a       = '0;
        w_b       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(r_ptr) + k) % NREQ;
            if (!w_any && req_valid[idx]) begin
                w_any        = 1'b1;
                w_grant[idx] = 1'b1;
                w_gnt_idx    = IDW'(idx);
                w_op         = req_op[idx*OPW +: OPW];
                w_a          = req_a[idx*W +: W];
                w_b          = req_b[idx*W +: W];
            end
        end
    end

    assign req_ready = w_load ? w_grant : '0;
    assign w_xfer    = w_load && w_any;

    logic_op_unit #(.W(W)) u_unit (
        .i_a   (w_a),
        .i_b   (w_b),
        .i_op  (w_op),
        .o_y   (w_y),
        .o_err (w_err)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_xfer) w_state_nxt = ST_FULL;
            ST_FULL:  if (res_ready && !w_xfer) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Result stage boundary: one cycle from accept to res_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_EMPTY;
            r_ptr     <= IDW'(NREQ - 1);
            r_data_p1 <= '0;
            r_id_p1   <= '0;
            r_err_p1  <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_data_p1 <= w_y;
                r_id_p1   <= w_gnt_idx;
                r_err_p1  <= w_err;
                r_ptr     <= w_gnt_idx;
            end
            if (clr_count)
                r_count <= '0;
            else if (w_xfer && (r_count != '1))
                r_count <= r_count + 1'b1;
        end
    end

    assign res_data = r_data_p1;
    assign res_id   = r_id_p1;
    assign res_err  = r_err_p1;
    assign op_count = r_count;

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Directed, table-driven bench for logic_op_scheduler (W=8, NREQ=4, CNTW=4).
module tb_logic_op_scheduler;
    import logic_op_pkg::*;

    localparam int W    = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 4;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [3*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_a;
    logic [W*NREQ-1:0] req_b;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_data;
    logic [IDW-1:0]    res_id;
    logic              res_err;
    logic              clr_count;
    logic [CNTW-1:0]   op_count;

    int checks = 0;
    int errors = 0;

    logic_op_scheduler #(.W(W), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_err   (res_err),
        .clr_count (clr_count),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[3*i +: 3] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{3'd0, 8'hA5, 8'h0F, 8'h05, 1'b0};
        vecs[1] = '{3'd1, 8'hA5, 8'h0F, 8'hAF, 1'b0};
        vecs[2] = '{3'd2, 8'hA5, 8'h0F, 8'hFA, 1'b0};
        vecs[3] = '{3'd3, 8'hA5, 8'h0F, 8'hF0, 1'b0};
        vecs[4] = '{3'd4, 8'hA5, 8'h0F, 8'h50, 1'b0};
        vecs[5] = '{3'd5, 8'hA5, 8'h0F, 8'hAA, 1'b0};
        vecs[6] = '{3'd6, 8'hA5, 8'h0F, 8'h55, 1'b0};
        vecs[7] = '{3'd7, 8'hA5, 8'h0F, 8'h00, 1'b1};

        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        clr_count = 1'b0;
        #1;
        check("rst_valid", 32'(res_valid), 0);
        check("rst_data",  32'(res_data), 0);
        check("rst_id",    32'(res_id), 0);
        check("rst_err",   32'(res_err), 0);
        check("rst_count", 32'(op_count), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic AND from requester 0
        set_req(0, 3'd0, 8'hF0, 8'h3C);
        req_valid = 4'b0001;
        #1;
        check("t1_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("t1_valid", 32'(res_valid), 1);
        check("t1_data",  32'(res_data), 32'h30);
        check("t1_id",    32'(res_id), 0);
        check("t1_err",   32'(res_err), 0);
        check("t1_count", 32'(op_count), 1);

        // Op sweep on requester 2, back-to-back
        req_valid = 4'b0100;
        for (int v = 0; v < 8; v++) begin
            set_req(2, vecs[v].op, vecs[v].a, vecs[v].b);
            #1;
            check($sformatf("sweep%0d_ready", v), 32'(req_ready), 32'h4);
            tick();
            check($sformatf("sweep%0d_valid", v), 32'(res_valid), 1);
            check($sformatf("sweep%0d_data", v), 32'(res_data), 32'(vecs[v].exp_data));
            check($sformatf("sweep%0d_err", v), 32'(res_err), 32'(vecs[v].exp_err));
            check($sformatf("sweep%0d_id", v), 32'(res_id), 2);
        end
        req_valid = '0;
        tick();
        check("drain_valid", 32'(res_valid), 0);

        // Round-robin: park pointer at 3, then all requesters valid
        for (int i = 0; i < NREQ; i++) set_req(i, 3'd5, 8'(i), 8'h10);
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("rr%0d_valid", k), 32'(res_valid), 1);
            check($sformatf("rr%0d_id", k), 32'(res_id), 32'(k % 4));
            check($sformatf("rr%0d_data", k), 32'(res_data), 32'(8'h10 | 8'(k % 4)));
        end

        // Backpressure with all requesters still valid
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp%0d_ready", k), 32'(req_ready), 0);
            check($sformatf("bp%0d_valid", k), 32'(res_valid), 1);
            check($sformatf("bp%0d_id", k), 32'(res_id), 1);
            check($sformatf("bp%0d_data", k), 32'(res_data), 32'h11);
            tick();
        end
        res_ready = 1'b1;
        #1;
        check("bp_rel_ready", 32'(req_ready), 32'h4);
        tick();
        check("bp_rel_id",   32'(res_id), 2);
        check("bp_rel_data", 32'(res_data), 32'h12);

        // Counter saturation and clear priority
        req_valid = '0;
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        check("cnt_clr", 32'(op_count), 0);
        set_req(0, 3'd0, 8'hF0, 8'h3C);
        req_valid = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("cnt%0d", k), 32'(op_count), 32'((k > 15) ? 15 : k));
        end
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        check("cnt_clr_xfer", 32'(op_count), 0);
        check("cnt_clr_valid", 32'(res_valid), 1);
        tick();
        check("cnt_after_clr", 32'(op_count), 1);

        // Asynchronous reset while a result is held
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(res_valid), 0);
        check("arst_data",  32'(res_data), 0);
        check("arst_count", 32'(op_count), 0);
        req_valid = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_ready", 32'(req_ready), 32'h1);
        tick();
        check("arst_id",   32'(res_id), 0);
        check("arst_data2", 32'(res_data), 32'h30);
        check("arst_valid2", 32'(res_valid), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_op_scheduler.md
Name: logic_op_scheduler

Overview:
- Shares one W-bit, two-operand bitwise logic unit (AND/OR/NAND/NOT/NOR/XOR/XNOR) between NREQ requesters.
- Round-robin arbitration with a valid/ready handshake on each request port.
- Single registered result stage with valid/ready backpressure, requester ID tag and an illegal-op error flag.
- Sits between the control clients and the shared gate datapath; it is the only block that drives that datapath.

Parameters:
W, 8, operand/result width in bits
NREQ, 4, number of requesters (>=2)
IDW, 2, requester ID width, = clog2(NREQ)
CNTW, 16, width of the accepted-operation counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NREQ  request i valid
req_ready  out  NREQ  request i accepted this cycle
req_op  in  3*NREQ  op code of requester i, slice [3i+2:3i]
req_a  in  W*NREQ  operand a of requester i, slice [Wi+W-1:Wi]
req_b  in  W*NREQ  operand b of requester i
res_valid  out  1  result register holds a result
res_ready  in  1  consumer accepts result
res_data  out  W  result
res_id  out  IDW  index of requester that produced res_data
res_err  out  1  result came from reserved op code
clr_count  in  1  synchronous clear of op_count
op_count  out  CNTW  number of accepted requests, saturating

Behaviour:
- Reset (async assert, sync release): res_valid=0, res_data=0, res_id=0, res_err=0, op_count=0, rr pointer=NREQ-1, so requester 0 has top priority first.
- Op encoding: 0 AND a&b, 1 OR a|b, 2 NAND ~(a&b), 3 NOT ~b (a ignored), 4 NOR ~(a|b), 5 XOR a^b, 6 XNOR ~(a^b), 7 reserved.
  - Reserved op: result 0, res_err=1.
  - All other ops: res_err=0.
- Load enable: load = !res_valid || res_ready (the output stage can accept a new result this cycle).
- Arbitration is combinational from req_valid and the pointer.
  - Search order: ptr+1, ptr+2, …, wrapping mod NREQ.
  - The first valid requester found is granted.
  - req_ready[i] = load && grant[i]; at most one bit is set, and it is never set for an invalid requester.
- Transfer: req_valid[i] && req_ready[i].
  - On the next edge: res_data = op(a_i, b_i), res_id = i, res_err per op, res_valid = 1, ptr = i.
  - Latency is 1 cycle from accept to res_valid.
- No transfer while load=1: res_valid goes to 0 if res_ready was high, otherwise it holds.
- Backpressure: while res_valid && !res_ready, all req_ready=0 and res_data/res_id/res_err are held stable.
- Throughput: one result per cycle when res_ready stays high (pipelined drain and fill in the same cycle).
- Requesters must hold valid, op and operands stable until ready. The pointer moves only on transfer, so a waiting requester never loses its turn.
- Fairness: with all requesters continuously valid, the grant sequence is 0,1,…,NREQ-1,0,…; any valid requester is served within NREQ transfers.
- State machine, 2 states:
  - EMPTY (res_valid=0) -> FULL on transfer.
  - FULL, res_ready && transfer -> FULL.
  - FULL, res_ready && no transfer -> EMPTY.
  - FULL, !res_ready -> FULL.
- op_count: +1 per transfer; saturates at all-ones. clr_count=1 forces 0 and wins over a simultaneous transfer.
- Reset mid-operation: an in-flight result is discarded immediately; no result is produced for the pending request.

Decomposition:
- Package logic_op_pkg:
  - op enum: OP_AND=0, OP_OR, OP_NAND, OP_NOT, OP_NOR, OP_XOR, OP_XNOR, OP_RSVD=7.
  - OPW=3.
  - Function is_reserved(op).
- One sub-module, logic_op_unit: combinational, W-bit a, b, op in; y, err out. The scheduler instantiates it once, after the grant mux.
- The round-robin arbiter stays inline.

Test Plan:
1. Basic op, W=8, NREQ=4: after reset, req0 valid, op=0 (AND), a=0xF0, b=0x3C, res_ready=1 -> req_ready=4'b0001 in the same cycle; next cycle res_valid=1, res_data=0x30, res_id=0, res_err=0, op_count=1.
2. Op sweep: requester 2, a=0xA5, b=0x0F, ops 0..7 -> res_data 0x05, 0xAF, 0xFA, 0xF0, 0x50, 0xAA, 0x55, 0x00; res_err=1 only for op 7.
3. Round-robin: all four requesters continuously valid, res_ready=1 -> res_id sequence 0,1,2,3,0,1 on consecutive cycles, res_valid held high.
4. Backpressure: hold res_ready=0 for 5 cycles with res_valid=1 and all requesters valid -> req_ready=0 every cycle, res_data/res_id unchanged; release -> next grant is the requester after the last served one.
5. Counter, CNTW=4: 20 accepted requests -> op_count stops at 15; clr_count pulsed together with a transfer -> op_count=0 next cycle.
6. Async reset: drop rst_n mid-cycle while res_valid=1 -> res_valid, res_data and op_count go to 0 without waiting for a clock edge; after release, requester 0 wins over requester 3 when both are valid.
